ddr_dq_burst_datapath: RTL and testbench
========================================

Name: ddr_dq_burst_datapath

Overview:
- Parametrised DQ/DQS/DM burst engine in the drm_clock domain, between the DDR controller command sequencer and the DDR I/O flops.
- Write path: turns a write-start pulse plus per-cycle write data into next_dq_high/low, next_dqm_high/low, next_dqs_high/low and next_dqoe, including DQS preamble and postamble.
- Read path: counts CAS latency from a read-start pulse, then registers the externally captured input_dq_high/low halves into a valid-qualified, last-tagged read stream.
- Generalises the fixed 32-bit, single-beat DQ handling to any byte-multiple width and burst length, and adds command-collision checking.

Parameters:
- DQ_WIDTH, 32: DQ bits per DDR half-cycle; must be a multiple of 8. LANES = DQ_WIDTH/8.
- BURST_LENGTH, 4: DDR beats per burst (2, 4 or 8). BC = BURST_LENGTH/2 drm_clock cycles per burst.
- MAX_CAS, 7: largest legal cas_latency value.

Ports:
- drm_clock  in  1  sole clock
- drm_ctl_reset  in  1  synchronous, active-high reset
- cas_latency  in  3  read latency in drm_clock cycles; sampled at an accepted rd_start
- wr_start  in  1  write command issued this cycle
- wr_data  in  2*DQ_WIDTH  {high half, low half} for one drm_clock cycle
- wr_mask  in  2*LANES  {high, low} byte masks; 1 = masked
- wr_data_req  out  1  wr_data/wr_mask are sampled at the end of this cycle
- rd_start  in  1  read command issued this cycle
- input_dq_high  in  DQ_WIDTH  data captured during the clock-high half
- input_dq_low  in  DQ_WIDTH  data captured during the clock-low half
- rd_data  out  2*DQ_WIDTH  {high, low} read data
- rd_valid  out  1  rd_data is valid
- rd_last  out  1  final cycle of the burst
- next_dq_high, next_dq_low  out  DQ_WIDTH each
- next_dqm_high, next_dqm_low  out  LANES each
- next_dqs_high, next_dqs_low  out  LANES each
- next_dqoe  out  1
- busy  out  1  either FSM is not idle
- cmd_error  out  1  sticky flag for a rejected command; cleared only by reset

Behaviour:
- Reset: all outputs are 0 at the first edge with drm_ctl_reset=1; both FSMs go to IDLE; in-flight bursts are abandoned and produce no rd_valid or DQS.
- Write FSM states: WR_IDLE, WR_PRE, WR_DATA, WR_POST. An accepted wr_start at cycle T gives:
  - T+1 is WR_PRE: next_dqoe=1, DQS=0, dq=0, wr_data_req=1.
  - WR_DATA occupies T+2..T+1+BC. Outputs are the wr_data/wr_mask sampled in the previous cycle; next_dqs_high=all-1, next_dqs_low=0, dqoe=1. wr_data_req=1 for T+1..T+BC.
  - T+2+BC is WR_POST: dqoe=1, DQS=0, dq holds its last value, dqm=all-1.
  - T+3+BC returns to WR_IDLE with dqoe=0.
  - A beat counter runs 0..BC-1 in WR_DATA.
- Read FSM states: RD_IDLE, RD_WAIT, RD_DATA. An accepted rd_start at T latches L = max(cas_latency, 1), clamped to MAX_CAS.
  - Input halves are valid during T+L..T+L+BC-1 and are registered, so rd_valid=1 for T+L+1..T+L+BC.
  - rd_last=1 on the final valid cycle.
  - rd_data = {input_dq_high, input_dq_low} from the previous cycle.
  - A countdown counter handles the wait; a beat counter handles the data phase.
- Acceptance rules:
  - rd_start is accepted only when both FSMs are idle.
  - wr_start is accepted only when both FSMs are idle and rd_start is not also asserted; the read wins a tie.
  - Any rejected start sets cmd_error and has no other effect.
- Back-to-back write: a wr_start in the WR_POST cycle is rejected, giving a minimum one-cycle gap that keeps the postamble intact.
- cas_latency changes while busy do not affect the burst in flight.
- busy = (write FSM != WR_IDLE) | (read FSM != RD_IDLE).

Decomposition:
- Package ddr_dq_types holds:
  - the write and read state enums;
  - the BC, LANES and counter-width functions (clog2(BC), clog2(MAX_CAS+1));
  - the DQS_ON and DQS_OFF lane constants.
- One natural sub-module, ddr_dq_read_return, contains the read FSM and the rd_data/rd_valid/rd_last registers. The write FSM, output muxing and collision logic remain in the top module.

Test Plan:
- Reset then idle: every output is 0, busy=0, cmd_error=0.
- Write, BL4, DQ_WIDTH=32: wr_start at T, wr_data 0xAAAA0001_5555_0001 then 0xAAAA0002_5555_0002 at T+1 and T+2. Required: next_dq_high/low = 0xAAAA0001/0x55550001 at T+2 and 0xAAAA0002/0x55550002 at T+3; dqoe=1 for T+1..T+4; dqs_high=0xF only at T+2..T+3; wr_mask=0x0F gives dqm_low=0xF and dqm_high=0.
- Read with cas_latency=3, BL8: rd_start at T, input halves counting 1..8 from T+3. Required: rd_valid at T+4..T+7 with data {1,2}..{7,8}; rd_last at T+7; busy drops at T+8.
- Collision: rd_start and wr_start both asserted at T gives read only and cmd_error=1. A wr_start in WR_POST is rejected. A rd_start during RD_WAIT is rejected with no extra rd_valid.
- Reset mid-burst: drm_ctl_reset at T+2 of a write gives dqoe=0 and DQS=0 at the next edge. Repeating it during RD_DATA gives rd_valid=0 at the next edge and no further valid cycles.
- cas_latency=0 behaves as 1: data valid at T+1 gives rd_valid at T+2.

Source files
------------

// File: rtl/ddr_dq_burst_datapath_pkg.sv
// Shared types and sizing helpers for the DDR DQ/DQS/DM burst datapath.
// Lane and burst sizes are derived here so the top and the read block agree.
package ddr_dq_types;

    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_PRE  = 2'd1,
        WR_DATA = 2'd2,
        WR_POST = 2'd3
    } wr_state_e;

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_WAIT = 2'd1,
        RD_DATA = 2'd2
    } rd_state_e;

    // Per-lane DQS level; replicated across LANES by the users.
    localparam logic DQS_ON  = 1'b1;
    localparam logic DQS_OFF = 1'b0;

    function automatic int burst_cycles(input int burst_length);
        return burst_length / 2;
    endfunction

    function automatic int lane_count(input int dq_width);
        return dq_width / 8;
    endfunction

    function automatic int beat_cnt_w(input int bc);
        return (bc > 1) ? $clog2(bc) : 1;
    endfunction

    function automatic int wait_cnt_w(input int max_cas);
        return $clog2(max_cas + 1);
    endfunction

endpackage

// File: rtl/ddr_dq_burst_datapath_read_return.sv
// Read return path: waits out CAS latency after an accepted read, then
// registers the captured DQ halves into a valid/last-qualified stream.
module ddr_dq_read_return
    import ddr_dq_types::*;
#(
    parameter int DQ_WIDTH     = 32,
    parameter int BURST_LENGTH = 4,
    parameter int MAX_CAS      = 7
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [2:0]            cas_latency_i,
    input  logic [DQ_WIDTH-1:0]   dq_high_i,
    input  logic [DQ_WIDTH-1:0]   dq_low_i,
    output logic [2*DQ_WIDTH-1:0] rd_data_o,
    output logic                  rd_valid_o,
    output logic                  rd_last_o,
    output rd_state_e             state_o
);

    localparam int BC = burst_cycles(BURST_LENGTH);
    localparam int BW = beat_cnt_w(BC);
    localparam int CW = wait_cnt_w(MAX_CAS);

    rd_state_e             state_q;
    logic [CW-1:0]         wait_q;
    logic [BW-1:0]         beat_q;
    logic [2*DQ_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;
    logic                  rd_last_q;

    int            lat_cycles;
    logic [CW-1:0] wait_start;

    // A latency of zero is treated as one; the countdown starts at L-1.
    always_comb begin
        lat_cycles = int'(cas_latency_i);
        if (lat_cycles < 1) begin
            lat_cycles = 1;
        end else if (lat_cycles > MAX_CAS) begin
            lat_cycles = MAX_CAS;
        end
        wait_start = CW'(lat_cycles - 1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= RD_IDLE;
            wait_q     <= '0;
            beat_q     <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
        end else begin
            case (state_q)
                RD_IDLE: begin
                    rd_valid_q <= 1'b0;
                    rd_last_q  <= 1'b0;
                    if (start_i) begin
                        state_q <= RD_WAIT;
                        wait_q  <= wait_start;
                    end
                end
                RD_WAIT: begin
                    if (wait_q == '0) begin
                        state_q    <= RD_DATA;
                        beat_q     <= '0;
                        rd_data_q  <= {dq_high_i, dq_low_i};
                        rd_valid_q <= 1'b1;
                        rd_last_q  <= (BC == 1);
                    end else begin
                        wait_q <= wait_q - CW'(1);
                    end
                end
                RD_DATA: begin
                    // beat_q counts the registered beats already presented.
                    if (beat_q == BW'(BC - 1)) begin
                        state_q    <= RD_IDLE;
                        rd_valid_q <= 1'b0;
                        rd_last_q  <= 1'b0;
                    end else begin
                        beat_q     <= beat_q + BW'(1);
                        rd_data_q  <= {dq_high_i, dq_low_i};
                        rd_valid_q <= 1'b1;
                        rd_last_q  <= (int'(beat_q) == BC - 2);
                    end
                end
                default: state_q <= RD_IDLE;
            endcase
        end
    end

    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;
    assign rd_last_o  = rd_last_q;
    assign state_o    = state_q;

endmodule

// File: rtl/ddr_dq_burst_datapath.sv
// DQ/DQS/DM burst engine: write FSM with DQS preamble/postamble, command
// collision checking, and the read return path as a sub-block.
module ddr_dq_burst_datapath
    import ddr_dq_types::*;
#(
    parameter int DQ_WIDTH     = 32,
    parameter int BURST_LENGTH = 4,
    parameter int MAX_CAS      = 7,
    localparam int LANES       = lane_count(DQ_WIDTH)
) (
    input  logic                  drm_clock,
    input  logic                  drm_ctl_reset,
    input  logic [2:0]            cas_latency,
    input  logic                  wr_start,
    input  logic [2*DQ_WIDTH-1:0] wr_data,
    input  logic [2*LANES-1:0]    wr_mask,
    output logic                  wr_data_req,
    input  logic                  rd_start,
    input  logic [DQ_WIDTH-1:0]   input_dq_high,
    input  logic [DQ_WIDTH-1:0]   input_dq_low,
    output logic [2*DQ_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  rd_last,
    output logic [DQ_WIDTH-1:0]   next_dq_high,
    output logic [DQ_WIDTH-1:0]   next_dq_low,
    output logic [LANES-1:0]      next_dqm_high,
    output logic [LANES-1:0]      next_dqm_low,
    output logic [LANES-1:0]      next_dqs_high,
    output logic [LANES-1:0]      next_dqs_low,
    output logic                  next_dqoe,
    output logic                  busy,
    output logic                  cmd_error
);

    localparam int BC = burst_cycles(BURST_LENGTH);
    localparam int BW = beat_cnt_w(BC);

    wr_state_e             wr_state_q;
    rd_state_e             rd_state;
    logic [BW-1:0]         wr_beat_q;
    logic [DQ_WIDTH-1:0]   dq_high_q, dq_low_q;
    logic [LANES-1:0]      dqm_high_q, dqm_low_q, dqs_high_q;
    logic                  dqoe_q, wr_req_q;
    logic                  cmd_error_q, cmd_error_d;
    logic                  both_idle, rd_accept, wr_accept, rejected;

    // A read wins a same-cycle tie; every refused start is flagged.
    always_comb begin
        both_idle   = (wr_state_q == WR_IDLE) && (rd_state == RD_IDLE);
        rd_accept   = rd_start && both_idle;
        wr_accept   = wr_start && both_idle && !rd_start;
        rejected    = (rd_start && !both_idle) || (wr_start && !wr_accept);
        cmd_error_d = cmd_error_q | rejected;
    end

    always_ff @(posedge drm_clock) begin
        if (drm_ctl_reset) begin
            cmd_error_q <= 1'b0;
        end else begin
            cmd_error_q <= cmd_error_d;
        end
    end

    always_ff @(posedge drm_clock) begin
        if (drm_ctl_reset) begin
            wr_state_q <= WR_IDLE;
            wr_beat_q  <= '0;
            dq_high_q  <= '0;
            dq_low_q   <= '0;
            dqm_high_q <= '0;
            dqm_low_q  <= '0;
            dqs_high_q <= {LANES{DQS_OFF}};
            dqoe_q     <= 1'b0;
            wr_req_q   <= 1'b0;
        end else begin
            case (wr_state_q)
                WR_IDLE: begin
                    dq_high_q  <= '0;
                    dq_low_q   <= '0;
                    dqm_high_q <= '0;
                    dqm_low_q  <= '0;
                    dqs_high_q <= {LANES{DQS_OFF}};
                    dqoe_q     <= wr_accept;
                    wr_req_q   <= wr_accept;
                    if (wr_accept) begin
                        wr_state_q <= WR_PRE;
                    end
                end
                WR_PRE: begin
                    wr_state_q <= WR_DATA;
                    wr_beat_q  <= '0;
                    dq_high_q  <= wr_data[2*DQ_WIDTH-1:DQ_WIDTH];
                    dq_low_q   <= wr_data[DQ_WIDTH-1:0];
                    dqm_high_q <= wr_mask[2*LANES-1:LANES];
                    dqm_low_q  <= wr_mask[LANES-1:0];
                    dqs_high_q <= {LANES{DQS_ON}};
                    dqoe_q     <= 1'b1;
                    wr_req_q   <= (BC > 1);
                end
                WR_DATA: begin
                    if (wr_beat_q == BW'(BC - 1)) begin
                        // Postamble: drive stays on, data held, all bytes masked.
                        wr_state_q <= WR_POST;
                        dqm_high_q <= '1;
                        dqm_low_q  <= '1;
                        dqs_high_q <= {LANES{DQS_OFF}};
                        wr_req_q   <= 1'b0;
                    end else begin
                        wr_beat_q  <= wr_beat_q + BW'(1);
                        dq_high_q  <= wr_data[2*DQ_WIDTH-1:DQ_WIDTH];
                        dq_low_q   <= wr_data[DQ_WIDTH-1:0];
                        dqm_high_q <= wr_mask[2*LANES-1:LANES];
                        dqm_low_q  <= wr_mask[LANES-1:0];
                        wr_req_q   <= (int'(wr_beat_q) < BC - 2);
                    end
                end
                WR_POST: begin
                    wr_state_q <= WR_IDLE;
                    dq_high_q  <= '0;
                    dq_low_q   <= '0;
                    dqm_high_q <= '0;
                    dqm_low_q  <= '0;
                    dqs_high_q <= {LANES{DQS_OFF}};
                    dqoe_q     <= 1'b0;
                    wr_req_q   <= 1'b0;
                end
                default: wr_state_q <= WR_IDLE;
            endcase
        end
    end

    ddr_dq_read_return #(
        .DQ_WIDTH     (DQ_WIDTH),
        .BURST_LENGTH (BURST_LENGTH),
        .MAX_CAS      (MAX_CAS)
    ) u_read_return (
        .clk_i         (drm_clock),
        .rst_i         (drm_ctl_reset),
        .start_i       (rd_accept),
        .cas_latency_i (cas_latency),
        .dq_high_i     (input_dq_high),
        .dq_low_i      (input_dq_low),
        .rd_data_o     (rd_data),
        .rd_valid_o    (rd_valid),
        .rd_last_o     (rd_last),
        .state_o       (rd_state)
    );

    assign next_dq_high  = dq_high_q;
    assign next_dq_low   = dq_low_q;
    assign next_dqm_high = dqm_high_q;
    assign next_dqm_low  = dqm_low_q;
    assign next_dqs_high = dqs_high_q;
    assign next_dqs_low  = {LANES{DQS_OFF}};
    assign next_dqoe     = dqoe_q;
    assign wr_data_req   = wr_req_q;
    assign busy          = (wr_state_q != WR_IDLE) | (rd_state != RD_IDLE);
    assign cmd_error     = cmd_error_q;

endmodule

// File: tb/tb_ddr_dq_burst_datapath.sv
// Bench for ddr_dq_burst_datapath: a BL4 and a BL8 instance share stimulus and
// are checked every cycle against a burst-window model, plus directed cases.
module tb_ddr_dq_burst_datapath;

    localparam int NONE = -1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, ws, rs;
    logic [2:0]  cas;
    logic [63:0] wd;
    logic [7:0]  wm;
    logic [31:0] ih, il;

    logic [31:0] o_dqh[2], o_dql[2];
    logic [3:0]  o_dqmh[2], o_dqml[2], o_dqsh[2], o_dqsl[2];
    logic        o_oe[2], o_req[2], o_busy[2], o_err[2], o_v[2], o_last[2];
    logic [63:0] o_rd[2];

    ddr_dq_burst_datapath #(.DQ_WIDTH(32), .BURST_LENGTH(4), .MAX_CAS(7)) u_bl4 (
        .drm_clock(clk), .drm_ctl_reset(rst), .cas_latency(cas),
        .wr_start(ws), .wr_data(wd), .wr_mask(wm), .wr_data_req(o_req[0]),
        .rd_start(rs), .input_dq_high(ih), .input_dq_low(il),
        .rd_data(o_rd[0]), .rd_valid(o_v[0]), .rd_last(o_last[0]),
        .next_dq_high(o_dqh[0]), .next_dq_low(o_dql[0]),
        .next_dqm_high(o_dqmh[0]), .next_dqm_low(o_dqml[0]),
        .next_dqs_high(o_dqsh[0]), .next_dqs_low(o_dqsl[0]),
        .next_dqoe(o_oe[0]), .busy(o_busy[0]), .cmd_error(o_err[0])
    );

    ddr_dq_burst_datapath #(.DQ_WIDTH(32), .BURST_LENGTH(8), .MAX_CAS(7)) u_bl8 (
        .drm_clock(clk), .drm_ctl_reset(rst), .cas_latency(cas),
        .wr_start(ws), .wr_data(wd), .wr_mask(wm), .wr_data_req(o_req[1]),
        .rd_start(rs), .input_dq_high(ih), .input_dq_low(il),
        .rd_data(o_rd[1]), .rd_valid(o_v[1]), .rd_last(o_last[1]),
        .next_dq_high(o_dqh[1]), .next_dq_low(o_dql[1]),
        .next_dqm_high(o_dqmh[1]), .next_dqm_low(o_dqml[1]),
        .next_dqs_high(o_dqsh[1]), .next_dqs_low(o_dqsl[1]),
        .next_dqoe(o_oe[1]), .busy(o_busy[1]), .cmd_error(o_err[1])
    );

    // Reference model: each burst is a start cycle plus a latency; the
    // expected outputs at any cycle follow from the offset to that start.
    int          cyc, n_cmp, n_bad;
    int          tw[2], tr[2], lat[2];
    bit          err[2];
    logic [63:0] wd_h[int];
    logic [7:0]  wm_h[int];
    logic [31:0] ih_h[int], il_h[int];

    function automatic int bc_of(input int i);
        return (i == 0) ? 2 : 4;
    endfunction

    function automatic bit m_busy(input int i, input int c);
        int kw, kr;
        kw = c - tw[i];
        kr = c - tr[i];
        return (kw >= 1 && kw <= 2 + bc_of(i)) || (kr >= 1 && kr <= lat[i] + bc_of(i));
    endfunction

    task automatic chk(input string name, input int i, input logic [127:0] got,
                       input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s bl%0d cyc=%0d got=%h exp=%h", name, (i == 0) ? 4 : 8,
                     cyc, got, exp);
        end
    endtask

    task automatic model_check();
        int          bc, kw, kr;
        logic [31:0] e_dqh, e_dql;
        logic [3:0]  e_dqmh, e_dqml, e_dqsh;
        logic        e_oe, e_req, e_v, e_last;
        for (int i = 0; i < 2; i++) begin
            bc = bc_of(i);
            kw = cyc - tw[i];
            kr = cyc - tr[i];
            {e_dqh, e_dql, e_dqmh, e_dqml, e_dqsh, e_oe, e_req} = '0;
            if (kw == 1) begin
                e_oe  = 1'b1;
                e_req = 1'b1;
            end else if (kw >= 2 && kw <= 1 + bc) begin
                {e_dqh, e_dql}   = wd_h[cyc-1];
                {e_dqmh, e_dqml} = wm_h[cyc-1];
                e_dqsh = 4'hF;
                e_oe   = 1'b1;
                e_req  = (kw <= bc);
            end else if (kw == 2 + bc) begin
                {e_dqh, e_dql} = wd_h[cyc-2];
                e_dqmh = 4'hF;
                e_dqml = 4'hF;
                e_oe   = 1'b1;
            end
            e_v    = (kr >= lat[i] + 1 && kr <= lat[i] + bc);
            e_last = (kr == lat[i] + bc);
            chk("write_outs", i,
                {o_dqh[i], o_dql[i], o_dqmh[i], o_dqml[i], o_dqsh[i], o_dqsl[i], o_oe[i], o_req[i]},
                {e_dqh, e_dql, e_dqmh, e_dqml, e_dqsh, 4'h0, e_oe, e_req});
            chk("status", i, {o_busy[i], o_err[i]}, {m_busy(i, cyc), err[i]});
            chk("read_ctl", i, {o_v[i], o_last[i]}, {e_v, e_last});
            if (e_v) chk("read_data", i, o_rd[i], {ih_h[cyc-1], il_h[cyc-1]});
        end
    endtask

    task automatic model_update();
        bit b;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                tw[i]  = NONE;
                tr[i]  = NONE;
                err[i] = 1'b0;
            end else begin
                b = m_busy(i, cyc);
                if (rs) begin
                    if (!b) begin
                        tr[i]  = cyc;
                        lat[i] = (cas == 3'd0) ? 1 : int'(cas);
                    end else begin
                        err[i] = 1'b1;
                    end
                end
                if (ws) begin
                    if (!b && !rs) tw[i] = cyc;
                    else err[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic step(input bit r, input bit w, input bit s, input logic [2:0] c,
                        input logic [63:0] d, input logic [7:0] m,
                        input logic [31:0] h, input logic [31:0] l);
        rst = r; ws = w; rs = s; cas = c; wd = d; wm = m; ih = h; il = l;
        wd_h[cyc] = d; wm_h[cyc] = m; ih_h[cyc] = h; il_h[cyc] = l;
        @(negedge clk);
    endtask

    task automatic finish_cycle();
        model_check();
        model_update();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            step(0, 0, 0, 3'd0, 64'h0, 8'h0, 32'h0, 32'h0);
            finish_cycle();
        end
    endtask

    typedef struct {
        bit          ws;
        logic [63:0] wd;
        logic [7:0]  wm;
        logic [31:0] e_dqh, e_dql;
        logic [3:0]  e_dqmh, e_dqml, e_dqsh;
        bit          e_oe;
    } wvec_t;

    wvec_t wt[6];
    int    nv[2];

    initial begin
        // Write BL4 cycles T..T+5: start, two data beats, then idle inputs.
        wt[0] = '{1'b1, 64'h0, 8'h00, 32'h0, 32'h0, 4'h0, 4'h0, 4'h0, 1'b0};
        wt[1] = '{1'b0, 64'hAAAA0001_55550001, 8'h0F, 32'h0, 32'h0, 4'h0, 4'h0, 4'h0, 1'b1};
        wt[2] = '{1'b0, 64'hAAAA0002_55550002, 8'h0F, 32'hAAAA0001, 32'h55550001, 4'h0, 4'hF, 4'hF, 1'b1};
        wt[3] = '{1'b0, 64'h0, 8'h00, 32'hAAAA0002, 32'h55550002, 4'h0, 4'hF, 4'hF, 1'b1};
        wt[4] = '{1'b0, 64'h0, 8'h00, 32'hAAAA0002, 32'h55550002, 4'hF, 4'hF, 4'h0, 1'b1};
        wt[5] = '{1'b0, 64'h0, 8'h00, 32'h0, 32'h0, 4'h0, 4'h0, 4'h0, 1'b0};

        n_cmp = 0; n_bad = 0; cyc = 0;
        for (int i = 0; i < 2; i++) begin
            tw[i] = NONE; tr[i] = NONE; lat[i] = 1; err[i] = 1'b0;
        end
        rst = 1'b1; ws = 1'b0; rs = 1'b0; cas = 3'd0; wd = '0; wm = '0; ih = '0; il = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state.
        step(1, 0, 0, 3'd0, 64'h0, 8'h0, 32'h0, 32'h0);
        for (int i = 0; i < 2; i++)
            chk("reset_zero", i,
                {o_dqh[i], o_dql[i], o_dqmh[i], o_dqml[i], o_dqsh[i], o_dqsl[i], o_oe[i],
                 o_req[i], o_busy[i], o_err[i], o_v[i], o_last[i], o_rd[i]}, '0);
        finish_cycle();
        idle(3);

        // Write burst table on the BL4 instance.
        for (int k = 0; k < 6; k++) begin
            step(0, wt[k].ws, 0, 3'd0, wt[k].wd, wt[k].wm, 32'h0, 32'h0);
            chk("wr_tbl_dq", 0, {o_dqh[0], o_dql[0]}, {wt[k].e_dqh, wt[k].e_dql});
            chk("wr_tbl_ctl", 0, {o_oe[0], o_dqsh[0], o_dqmh[0], o_dqml[0]},
                {wt[k].e_oe, wt[k].e_dqsh, wt[k].e_dqmh, wt[k].e_dqml});
            finish_cycle();
        end
        idle(6);

        // Read CL3 on the BL8 instance, halves counting 1..8 from T+3.
        for (int k = 0; k < 10; k++) begin
            step(0, 0, (k == 0), 3'd3, 64'h0, 8'h0,
                 (k >= 3 && k <= 6) ? 32'(2 * (k - 3) + 1) : 32'h0,
                 (k >= 3 && k <= 6) ? 32'(2 * (k - 3) + 2) : 32'h0);
            chk("rd8_vlb", 1, {o_v[1], o_last[1], o_busy[1]},
                {(k >= 4 && k <= 7), (k == 7), (k >= 1 && k <= 7)});
            if (k >= 4 && k <= 7)
                chk("rd8_data", 1, o_rd[1], {32'(2 * (k - 4) + 1), 32'(2 * (k - 4) + 2)});
            finish_cycle();
        end

        // Tie: read wins, write refused and flagged.
        step(0, 1, 1, 3'd2, 64'h1234, 8'h0, 32'h0, 32'h0);
        finish_cycle();
        step(0, 0, 0, 3'd2, 64'h0, 8'h0, 32'h0, 32'h0);
        for (int i = 0; i < 2; i++)
            chk("tie_err", i, {o_err[i], o_busy[i], o_oe[i]}, 3'b110);
        finish_cycle();
        idle(10);
        step(1, 0, 0, 3'd0, 64'h0, 8'h0, 32'h0, 32'h0);
        finish_cycle();

        // Write then a start in the BL4 postamble cycle.
        step(0, 1, 0, 3'd0, 64'h0, 8'h0, 32'h0, 32'h0);
        finish_cycle();
        idle(3);
        step(0, 1, 0, 3'd0, 64'h0, 8'h0, 32'h0, 32'h0);
        chk("post_state", 0, {o_oe[0], o_dqmh[0], o_dqml[0], o_dqsh[0]}, {1'b1, 4'hF, 4'hF, 4'h0});
        finish_cycle();
        step(0, 0, 0, 3'd0, 64'h0, 8'h0, 32'h0, 32'h0);
        chk("post_reject", 0, {o_err[0], o_oe[0], o_busy[0]}, 3'b100);
        finish_cycle();
        idle(6);
        step(1, 0, 0, 3'd0, 64'h0, 8'h0, 32'h0, 32'h0);
        finish_cycle();

        // Read CL5 with a second start during the wait.
        nv[0] = 0; nv[1] = 0;
        for (int k = 0; k < 14; k++) begin
            step(0, 0, (k == 0 || k == 2), 3'd5, 64'h0, 8'h0, $urandom, $urandom);
            if (o_v[0]) nv[0]++;
            if (o_v[1]) nv[1]++;
            finish_cycle();
        end
        chk("wait_reject_cnt", 0, 128'(nv[0]), 128'd2);
        chk("wait_reject_cnt", 1, 128'(nv[1]), 128'd4);
        chk("wait_reject_err", 0, {o_err[0]}, 1'b1);
        step(1, 0, 0, 3'd0, 64'h0, 8'h0, 32'h0, 32'h0);
        finish_cycle();

        // Reset two cycles into a write.
        step(0, 1, 0, 3'd0, 64'h0, 8'h0, 32'h0, 32'h0);
        finish_cycle();
        step(0, 0, 0, 3'd0, 64'hDEAD_BEEF_0BAD_F00D, 8'h33, 32'h0, 32'h0);
        finish_cycle();
        step(1, 0, 0, 3'd0, 64'h0, 8'h0, 32'h0, 32'h0);
        finish_cycle();
        step(0, 0, 0, 3'd0, 64'h0, 8'h0, 32'h0, 32'h0);
        for (int i = 0; i < 2; i++)
            chk("wr_reset", i, {o_oe[i], o_dqsh[i], o_busy[i]}, 6'b0);
        finish_cycle();

        // Reset during the first valid read cycle (CL1).
        step(0, 0, 1, 3'd1, 64'h0, 8'h0, 32'h0, 32'h0);
        finish_cycle();
        step(0, 0, 0, 3'd1, 64'h0, 8'h0, 32'h5A5A5A5A, 32'hA5A5A5A5);
        finish_cycle();
        nv[0] = 0;
        for (int k = 0; k < 7; k++) begin
            step((k == 0), 0, 0, 3'd1, 64'h0, 8'h0, 32'h11111111, 32'h22222222);
            if (k == 0) chk("rd_before_reset", 0, {o_v[0]}, 1'b1);
            if (k > 0 && (o_v[0] || o_v[1])) nv[0]++;
            finish_cycle();
        end
        chk("rd_reset_no_valid", 0, 128'(nv[0]), 128'd0);

        // CL0 behaves as CL1.
        step(0, 0, 1, 3'd0, 64'h0, 8'h0, 32'h0, 32'h0);
        finish_cycle();
        step(0, 0, 0, 3'd0, 64'h0, 8'h0, 32'h11110001, 32'h22220001);
        chk("cl0_not_yet", 0, {o_v[0]}, 1'b0);
        finish_cycle();
        step(0, 0, 0, 3'd0, 64'h0, 8'h0, 32'h11110002, 32'h22220002);
        chk("cl0_valid", 0, {o_v[0], o_rd[0]}, {1'b1, 64'h11110001_22220001});
        finish_cycle();
        idle(8);

        // Randomised traffic against the model.
        for (int k = 0; k < 800; k++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 7) == 0), 3'($urandom_range(0, 7)),
                 {$urandom, $urandom}, 8'($urandom_range(0, 255)), $urandom, $urandom);
            finish_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
